// File: rtl/uart_tx_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_POP       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

    function automatic int ptr_width(input int num_src);
        return (num_src < 2) ? 1 : $clog2(num_src);
    endfunction

    function automatic int cnt_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

    localparam int DEF_NUM_SRC   = 2;
    localparam int DEF_BURST_MAX = 16;
    localparam int DEF_PTR_W     = ptr_width(DEF_NUM_SRC);
    localparam int DEF_CNT_W     = cnt_width(DEF_BURST_MAX);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-FIFO and UART-side signals of the arbiter, plus the FSM state for observation.
//
// Handshake: a source is popped by a one-cycle o_src_rd strobe only while its
// i_src_valid is known high; o_tx_data_valid is a one-cycle pulse with o_tx_data
// stable, and the UART answers with a one-cycle i_tx_done when the byte is out.
interface uart_tx_arbiter_if
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_SRC-1:0]        i_src_valid;
    logic [NUM_SRC*DATA_W-1:0] i_src_data;
    logic [NUM_SRC-1:0]        o_src_rd;
    logic [DATA_W-1:0]         o_tx_data;
    logic                      o_tx_data_valid;
    logic                      i_tx_done;
    logic [NUM_SRC-1:0]        o_grant;
    logic                      o_busy;
    arb_state_t                dbg_state;

    modport slave (
        input  i_src_valid, i_src_data, i_tx_done,
        output o_src_rd, o_tx_data, o_tx_data_valid, o_grant, o_busy, dbg_state
    );

    modport master (
        output i_src_valid, i_src_data, i_tx_done,
        input  o_src_rd, o_tx_data, o_tx_data_valid, o_grant, o_busy, dbg_state
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int PTR_W   = ptr_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   idx
);
    localparam int JW = PTR_W + 1;

    always_comb begin : pick
        logic [JW-1:0] j;
        logic          found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = {1'b0, ptr} + JW'(k);
            if (j >= JW'(NUM_SRC)) begin
                j = j - JW'(NUM_SRC);
            end
            if (!found && req[j[PTR_W-1:0]]) begin
                found                = 1'b1;
                grant[j[PTR_W-1:0]]  = 1'b1;
                idx                  = j[PTR_W-1:0];
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among several FWFT byte
// sources, holding each grant for a burst of up to BURST_MAX bytes.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = ptr_width(NUM_SRC);
    localparam int CNT_W = cnt_width(BURST_MAX);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_SRC - 1);

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] pick_grant;
    logic [NUM_SRC-1:0] src_rd;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               busy;

    logic [DATA_W-1:0]  src_word [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_word
        assign src_word[k] = bus.i_src_data[k*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (bus.i_src_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Strobes are registered on the transition into POP/SEND so every output
    // comes straight from a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gidx     <= '0;
            grant    <= '0;
            cnt      <= '0;
            src_rd   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            src_rd   <= '0;
            tx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.i_src_valid) begin
                        state <= ST_ARB;
                        busy  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    cnt <= '0;
                    if (|bus.i_src_valid) begin
                        grant  <= pick_grant;
                        gidx   <= pick_idx;
                        src_rd <= pick_grant;
                        state  <= ST_POP;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    tx_data  <= src_word[gidx];
                    cnt      <= cnt + CNT_W'(1);
                    tx_valid <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.i_tx_done) begin
                        if (cnt < BURST_LIM && bus.i_src_valid[gidx]) begin
                            src_rd <= grant;
                            state  <= ST_POP;
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            ptr   <= (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_src_rd        = src_rd;
    assign bus.o_tx_data       = tx_data;
    assign bus.o_tx_data_valid = tx_valid;
    assign bus.o_grant         = grant;
    assign bus.o_busy          = busy;
    assign bus.dbg_state       = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut_a (2 sources, burst 16) and dut_b (3 sources, burst 1)
// fed from queue-modelled FWFT FIFOs, with the UART done pulse driven by hand.
module tb_uart_tx_arbiter;
    import uart_tx_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_SRC(2), .DATA_W(8)) bus_a ();
    uart_tx_arbiter_if #(.NUM_SRC(3), .DATA_W(8)) bus_b ();

    uart_tx_arbiter #(.NUM_SRC(2), .DATA_W(8), .BURST_MAX(16)) dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    uart_tx_arbiter #(.NUM_SRC(3), .DATA_W(8), .BURST_MAX(1)) dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    int checks = 0;
    int fails  = 0;

    logic [7:0] qa0[$], qa1[$], qb0[$], qb1[$], qb2[$];
    int pops_a0 = 0, pops_a1 = 0;
    int vcnt_a = 0;
    int bad_grant = 0;
    logic [1:0] rd_d1_a;
    logic [2:0] rd_d1_b;

    task automatic refresh();
        bus_a.i_src_valid = {qa1.size() != 0, qa0.size() != 0};
        bus_a.i_src_data  = {(qa1.size() != 0) ? qa1[0] : 8'h00,
                             (qa0.size() != 0) ? qa0[0] : 8'h00};
        bus_b.i_src_valid = {qb2.size() != 0, qb1.size() != 0, qb0.size() != 0};
        bus_b.i_src_data  = {(qb2.size() != 0) ? qb2[0] : 8'h00,
                             (qb1.size() != 0) ? qb1[0] : 8'h00,
                             (qb0.size() != 0) ? qb0[0] : 8'h00};
    endtask

    // FIFO model: pop on the strobe seen at the edge, update heads mid-cycle.
    always begin : src_model
        logic [1:0] ra;
        logic [2:0] rb;
        @(posedge clk);
        ra = bus_a.o_src_rd;
        rb = bus_b.o_src_rd;
        #2;
        if (ra[0] && qa0.size() != 0) begin void'(qa0.pop_front()); pops_a0++; end
        if (ra[1] && qa1.size() != 0) begin void'(qa1.pop_front()); pops_a1++; end
        if (rb[0] && qb0.size() != 0) void'(qb0.pop_front());
        if (rb[1] && qb1.size() != 0) void'(qb1.pop_front());
        if (rb[2] && qb2.size() != 0) void'(qb2.pop_front());
        refresh();
    end

    always @(posedge clk) begin
        rd_d1_a <= bus_a.o_src_rd;
        rd_d1_b <= bus_b.o_src_rd;
    end

    always @(negedge clk) begin
        if (bus_a.o_tx_data_valid) vcnt_a++;
        if (bus_a.o_grant != 2'b00 && !$onehot(bus_a.o_grant)) bad_grant++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for the next valid pulse; exp_wait is sample cycles from call, -1 to skip.
    task automatic get_byte(input int sel, input logic [7:0] exp_data,
                            input logic [7:0] exp_grant, input int exp_wait,
                            input string tag);
        int n;
        logic seen;
        logic [7:0] d, g, r;
        n = 0; seen = 1'b0; d = '0; g = '0; r = '0;
        while (!seen && n < 3000) begin
            @(posedge clk); #1; n++;
            if (sel == 0) begin
                seen = bus_a.o_tx_data_valid; d = bus_a.o_tx_data;
                g = {6'b0, bus_a.o_grant};    r = {6'b0, rd_d1_a};
            end else begin
                seen = bus_b.o_tx_data_valid; d = bus_b.o_tx_data;
                g = {5'b0, bus_b.o_grant};    r = {5'b0, rd_d1_b};
            end
        end
        check({tag, " valid"}, 32'(seen), 32'd1);
        check({tag, " data"}, 32'(d), 32'(exp_data));
        check({tag, " grant"}, 32'(g), 32'(exp_grant));
        check({tag, " pop_before_valid"}, 32'(r), 32'(exp_grant));
        if (exp_wait >= 0) check({tag, " latency"}, n, exp_wait);
    endtask

    task automatic done_pulse(input int sel);
        @(posedge clk); #1;
        if (sel == 0) bus_a.i_tx_done = 1'b1; else bus_b.i_tx_done = 1'b1;
        @(posedge clk); #1;
        bus_a.i_tx_done = 1'b0;
        bus_b.i_tx_done = 1'b0;
    endtask

    task automatic idle_a(input string tag);
        check({tag, " state"}, 32'(bus_a.dbg_state), 32'(ST_IDLE));
        check({tag, " busy"}, 32'(bus_a.o_busy), 32'd0);
        check({tag, " grant"}, 32'(bus_a.o_grant), 32'd0);
    endtask

    initial begin : stim
        int p0, p1, v0, bad;
        logic [7:0] ed;
        bus_a.i_tx_done = 1'b0;
        bus_b.i_tx_done = 1'b0;
        refresh();

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a src_rd", 32'(bus_a.o_src_rd), 0);
        check("rst_a tx_data", 32'(bus_a.o_tx_data), 0);
        check("rst_a tx_valid", 32'(bus_a.o_tx_data_valid), 0);
        idle_a("rst_a");
        check("rst_b grant", 32'(bus_b.o_grant), 0);
        check("rst_b busy", 32'(bus_b.o_busy), 0);
        rst_a = 1'b0;
        @(posedge clk); #1;

        // Round-robin: 20 bytes each, bursts of 16.
        for (int i = 0; i < 20; i++) begin
            qa0.push_back(8'(i));
            qa1.push_back(8'h80 + 8'(i));
        end
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < ((blk < 2) ? 16 : 4); i++) begin
                ed = ((blk % 2) ? 8'h80 : 8'h00) + 8'((blk < 2) ? i : 16 + i);
                get_byte(0, ed, (blk % 2) ? 8'd2 : 8'd1, (i == 0) ? 3 : 1,
                         $sformatf("rr b%0d i%0d", blk, i));
                done_pulse(0);
            end
        end
        repeat (2) @(posedge clk); #1;
        idle_a("rr end");
        check("rr onehot", bad_grant, 0);
        check("rr pops0", pops_a0, 20);
        check("rr pops1", pops_a1, 20);

        // Single source 0 with 0xA5, 0x3C.
        p0 = pops_a0;
        qa0.push_back(8'hA5);
        qa0.push_back(8'h3C);
        get_byte(0, 8'hA5, 8'd1, 3, "single b0");
        done_pulse(0);
        get_byte(0, 8'h3C, 8'd1, 1, "single b1");
        done_pulse(0);
        repeat (2) @(posedge clk); #1;
        check("single pops", pops_a0 - p0, 2);
        idle_a("single end");

        // Stray done while idle.
        v0 = vcnt_a;
        done_pulse(0);
        repeat (3) @(posedge clk); #1;
        idle_a("stray idle");
        check("stray idle valids", vcnt_a - v0, 0);

        // Early release: ptr now at 1, source 1 holds only 3 bytes.
        p0 = pops_a0; p1 = pops_a1;
        qa1.push_back(8'h51); qa1.push_back(8'h52); qa1.push_back(8'h53);
        qa0.push_back(8'h61); qa0.push_back(8'h62);
        get_byte(0, 8'h51, 8'd2, 3, "early s1 b0");
        done_pulse(0);
        get_byte(0, 8'h52, 8'd2, 1, "early s1 b1");
        done_pulse(0);
        get_byte(0, 8'h53, 8'd2, 1, "early s1 b2");
        done_pulse(0);
        get_byte(0, 8'h61, 8'd1, 3, "early s0 b0");
        done_pulse(0);
        get_byte(0, 8'h62, 8'd1, 1, "early s0 b1");
        done_pulse(0);
        repeat (2) @(posedge clk); #1;
        check("early pops1", pops_a1 - p1, 3);
        check("early pops0", pops_a0 - p0, 2);

        // Stray done in SEND, then done held off for 1000 cycles.
        qa0.push_back(8'h77);
        get_byte(0, 8'h77, 8'd1, 3, "delay byte");
        bus_a.i_tx_done = 1'b1;
        @(posedge clk); #1;
        bus_a.i_tx_done = 1'b0;
        check("stray send state", 32'(bus_a.dbg_state), 32'(ST_WAIT_DONE));
        v0 = vcnt_a; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (bus_a.dbg_state != ST_WAIT_DONE || !bus_a.o_busy) bad++;
        end
        check("delay hold", bad, 0);
        check("delay valids", vcnt_a - v0, 0);
        done_pulse(0);
        repeat (2) @(posedge clk); #1;
        idle_a("delay end");

        // Reset during WAIT_DONE of a source 1 burst.
        p0 = pops_a0; p1 = pops_a1;
        qa1.push_back(8'h11); qa1.push_back(8'h12);
        qa1.push_back(8'h13); qa1.push_back(8'h14);
        get_byte(0, 8'h11, 8'd2, 3, "rst s1 b0");
        @(posedge clk); #1;
        check("rst pre state", 32'(bus_a.dbg_state), 32'(ST_WAIT_DONE));
        #2;
        rst_a = 1'b1;
        #1;
        check("mid rst src_rd", 32'(bus_a.o_src_rd), 0);
        check("mid rst tx_data", 32'(bus_a.o_tx_data), 0);
        check("mid rst tx_valid", 32'(bus_a.o_tx_data_valid), 0);
        idle_a("mid rst");
        @(posedge clk); #1;
        qa0.push_back(8'h21); qa0.push_back(8'h22);
        rst_a = 1'b0;
        get_byte(0, 8'h21, 8'd1, 3, "post rst s0 b0");
        done_pulse(0);
        get_byte(0, 8'h22, 8'd1, 1, "post rst s0 b1");
        done_pulse(0);
        get_byte(0, 8'h12, 8'd2, 3, "post rst s1 b0");
        done_pulse(0);
        get_byte(0, 8'h13, 8'd2, 1, "post rst s1 b1");
        done_pulse(0);
        get_byte(0, 8'h14, 8'd2, 1, "post rst s1 b2");
        done_pulse(0);
        repeat (2) @(posedge clk); #1;
        check("rst pops1", pops_a1 - p1, 4);
        check("rst pops0", pops_a0 - p0, 2);
        idle_a("rst end");

        // BURST_MAX = 1 with three sources: strict per-byte rotation.
        for (int i = 0; i < 2; i++) begin
            qb0.push_back(8'h10 + 8'(i));
            qb1.push_back(8'h20 + 8'(i));
            qb2.push_back(8'h30 + 8'(i));
        end
        rst_b = 1'b0;
        for (int r = 0; r < 6; r++) begin
            get_byte(1, 8'(16 * ((r % 3) + 1) + (r / 3)), 8'(1 << (r % 3)), 3,
                     $sformatf("b1 r%0d", r));
            done_pulse(1);
        end
        repeat (2) @(posedge clk); #1;
        check("b1 end grant", 32'(bus_b.o_grant), 0);
        check("b1 end busy", 32'(bus_b.o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
